// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// A valid/ready handshake sits on both sides. In signed mode the input is
// converted to sign + magnitude. A sticky overflow flag is set when the
// magnitude needs more than DIGITS decimal digits; bcd then holds
// magnitude mod 10^DIGITS.
module bcd_seq_converter #(
    parameter int BIN_W     = 14,
    parameter int DIGITS    = 4,
    parameter int SIGNED_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [BIN_W-1:0]   sreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [ACC_W-1:0]   adj;
    logic [ACC_W-1:0]   acc_d;
    logic [BIN_W-1:0]   sreg_d;
    logic               carry_out;
    logic               is_neg;
    logic [BIN_W-1:0]   mag;

    // Magnitude of the incoming operand; the most negative value maps to
    // 2^(BIN_W-1), which still fits in BIN_W unsigned bits.
    always_comb begin
        is_neg = (SIGNED_EN != 0) && bin[BIN_W-1];
        mag    = is_neg ? (~bin + 1'b1) : bin;
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
        carry_out = adj[ACC_W-1];
        acc_d     = {adj[ACC_W-2:0], sreg_q[BIN_W-1]};
        sreg_d    = {sreg_q[BIN_W-2:0], 1'b0};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sreg_q     <= mag;
                        neg_q      <= is_neg;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CNT_W'(BIN_W);
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q  <= acc_d;
                    sreg_q <= sreg_d;
                    // A carry out of the top digit is a 10^DIGITS unit lost.
                    if (carry_out)
                        ovf_q <= 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd       = acc_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: four configurations run in parallel, each with
// directed vectors, latency/backpressure/reset-mid-conversion scenarios and a
// randomized sweep. A scoreboard queue is filled at accept time from a
// decimal reference model and drained by an output monitor.
module tb_bcd_seq_converter;

    typedef struct {
        longint b;
        bit     n;
        bit     o;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d: got %0h expected %0h", name, g, act, exp);
        end
    endtask

    // Reference: interpret the raw bits, take |value|, then build decimal digits.
    function automatic void model(input longint raw, input int bw, input int dg, input int se,
                                  output longint eb, output bit en, output bit eo);
        longint v, mag, p, r;
        v = raw;
        if (se != 0 && raw[bw-1]) v = raw - (longint'(1) << bw);
        en  = (v < 0);
        mag = en ? -v : v;
        p = 1;
        for (int i = 0; i < dg; i++) p = p * 10;
        eo = (mag >= p);
        r  = mag % p;
        eb = 0;
        for (int d = 0; d < dg; d++) begin
            eb = eb | ((r % 10) << (4 * d));
            r  = r / 10;
        end
    endfunction

    function automatic longint directed_val(input int g, input int i);
        case (g)
            0: case (i) 0: return 9999;    1: return 12345;   2: return 10000;   3: return 0;   default: return 1;    endcase
            1: case (i) 0: return 'h2000;  1: return 'h3FFF;  2: return 'h1FFF;  3: return 0;   default: return 'h270F; endcase
            2: case (i) 0: return 999;     1: return 1000;    2: return 1023;    3: return 0;   default: return 512;  endcase
            default: case (i) 0: return 999999; 1: return 1000000; 2: return 1048575; 3: return 0; default: return 524288; endcase
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int BW = (g == 2) ? 10 : (g == 3) ? 20 : 14;
        localparam int DG = (g == 2) ? 3 : (g == 3) ? 6 : 4;
        localparam int SE = (g == 1) ? 1 : 0;

        logic              rst_n;
        logic              in_valid;
        logic              in_ready;
        logic [BW-1:0]     bin;
        logic              out_valid;
        logic              out_ready;
        logic [4*DG-1:0]   bcd;
        logic              neg;
        logic              ovf;
        bit                rnd_ordy = 1'b0;
        exp_t              q[$];

        bcd_seq_converter #(.BIN_W(BW), .DIGITS(DG), .SIGNED_EN(SE)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
            .bcd(bcd), .neg(neg), .ovf(ovf)
        );

        // Randomized consumer backpressure when enabled.
        initial begin
            forever begin
                @(posedge clk);
                #1;
                if (rnd_ordy) out_ready = ($urandom_range(0, 1) == 1);
            end
        end

        // Issue one request; optionally wait for its result and measure latency.
        task automatic send(input longint v, input bit wait_out, input bit pulse);
            int w;
            longint eb;
            bit en, eo;
            exp_t e;
            int lat;
            w = 0;
            while (!in_ready && w < 300) begin
                @(posedge clk); #1; w++;
            end
            chk("in_ready_wait", g, longint'(in_ready), 1);
            in_valid = 1'b1;
            bin = v[BW-1:0];
            @(posedge clk);
            model(v, BW, DG, SE, eb, en, eo);
            e.b = eb; e.n = en; e.o = eo;
            q.push_back(e);
            #1;
            in_valid = 1'b0;
            if (wait_out) begin
                lat = 0;
                while (!out_valid && lat < BW + 8) begin
                    if (pulse) begin
                        in_valid = 1'b1;
                        bin = BW'($urandom);
                    end
                    @(posedge clk); #1;
                    lat++;
                    if (pulse) chk("in_ready_shift", g, longint'(in_ready), 0);
                end
                in_valid = 1'b0;
                chk("latency", g, lat, BW);
            end
        endtask

        // Driver / scenario sequencer.
        initial begin
            longint v, mask, p, held;
            rst_n = 1'b0; in_valid = 1'b0; bin = '0; out_ready = 1'b1;
            mask = (longint'(1) << BW) - 1;
            p = 1;
            for (int i = 0; i < DG; i++) p = p * 10;
            repeat (2) @(posedge clk);
            #1;
            chk("rst_in_ready", g, longint'(in_ready), 1);
            chk("rst_out_valid", g, longint'(out_valid), 0);
            chk("rst_bcd", g, longint'(bcd), 0);
            chk("rst_ovf", g, longint'(ovf), 0);
            chk("rst_neg", g, longint'(neg), 0);
            rst_n = 1'b1;
            @(posedge clk); #1;

            for (int i = 0; i < 5; i++) begin
                send(directed_val(g, i), 1'b1, 1'b0);
                @(posedge clk); #1;
            end

            // Backpressure: result held for 6 cycles, stray requests ignored.
            out_ready = 1'b0;
            send(directed_val(g, 0), 1'b1, 1'b1);
            held = longint'(bcd);
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'b1;
                bin = BW'($urandom);
                @(posedge clk); #1;
                chk("bp_in_ready", g, longint'(in_ready), 0);
                chk("bp_out_valid", g, longint'(out_valid), 1);
                chk("bp_bcd_hold", g, longint'(bcd), held);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_release_in_ready", g, longint'(in_ready), 1);
            chk("bp_release_out_valid", g, longint'(out_valid), 0);
            repeat (3) @(posedge clk);
            #1;
            chk("bp_no_extra", g, longint'(out_valid), 0);

            // Asynchronous reset five edges into a conversion.
            send(mask, 1'b0, 1'b0);
            repeat (5) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            void'(q.pop_back());
            chk("mid_rst_in_ready", g, longint'(in_ready), 1);
            chk("mid_rst_out_valid", g, longint'(out_valid), 0);
            chk("mid_rst_bcd", g, longint'(bcd), 0);
            chk("mid_rst_ovf", g, longint'(ovf), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            send(255, 1'b1, 1'b0);
            @(posedge clk); #1;

            // Random sweep with random consumer backpressure.
            rnd_ordy = 1'b1;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) == 0)
                    v = (p - 2 + longint'($urandom_range(0, 3))) & mask;
                else
                    v = longint'({$urandom, $urandom}) & mask;
                send(v, 1'b0, 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
            chk("drain", g, q.size(), 0);
            rnd_ordy = 1'b0;
            done_cnt++;
        end

        // Output monitor: checks holding while stalled and pops on handshake.
        initial begin
            bit pv, pt;
            longint pb;
            bit pn, po;
            exp_t e;
            pv = 1'b0; pt = 1'b0; pb = 0; pn = 1'b0; po = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n && out_valid) begin
                    if (pv && !pt) begin
                        chk("hold_bcd", g, longint'(bcd), pb);
                        chk("hold_flags", g, {neg, ovf}, {pn, po});
                    end
                    if (out_ready) begin
                        if (q.size() == 0) begin
                            chk("unexpected_output", g, 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk("bcd", g, longint'(bcd), e.b);
                            chk("neg", g, longint'(neg), longint'(e.n));
                            chk("ovf", g, longint'(ovf), longint'(e.o));
                        end
                    end
                end
                pv = rst_n && out_valid;
                pt = out_ready;
                pb = longint'(bcd);
                pn = neg;
                po = ovf;
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (done_cnt < 4 && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < 4) begin
            errors++;
            $display("FAIL timeout: finished configs %0d expected 4", done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Sequential, parametrised binary-to-BCD converter using shift-add-3 (double dabble). It processes one input bit per clock instead of unrolling the loop combinationally, which keeps area flat as BIN_W grows.
- Adds a valid/ready handshake on both sides.
- Adds a sticky overflow flag when the value does not fit in DIGITS decimal digits.
- Adds an optional signed (sign-magnitude) mode.
- Feeds 7-segment and display drivers downstream.

Parameters:
BIN_W, 14, width of the binary input (>=2)
DIGITS, 4, number of BCD output digits (>=1)
SIGNED_EN, 0, 1 = treat bin as two's complement and output sign + magnitude; 0 = unsigned

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  bin is valid this cycle
in_ready  out  1  converter can accept bin (high only in IDLE)
bin  in  BIN_W  binary operand
out_valid  out  1  bcd/neg/ovf are valid and held
out_ready  in  1  consumer accepts result
bcd  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]
neg  out  1  input was negative (always 0 when SIGNED_EN=0)
ovf  out  1  |value| > 10^DIGITS-1; bcd then holds |value| mod 10^DIGITS

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. rst_n low forces IDLE, with bcd=0, neg=0, ovf=0, out_valid=0, in_ready=1, shift register=0, bit counter=0. This applies at any time, including mid-SHIFT or in DONE; any in-flight conversion is discarded with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, out_valid=0. On a rising edge with in_valid=1, the converter accepts bin:
  - Captures magnitude into shift register sreg (BIN_W bits). If SIGNED_EN and bin[BIN_W-1]=1: sreg = (~bin)+1 and neg<=1; otherwise sreg=bin and neg<=0.
  - Clears the BCD accumulator and ovf; loads bit counter = BIN_W; goes to SHIFT.
- SHIFT (in_ready=0, out_valid=0), per edge:
  1. For every digit d (0..DIGITS-1), if acc digit >= 5, add 3 (4-bit, no carry between digits).
  2. Shift {acc, sreg} left by 1; acc[0] takes sreg[BIN_W-1].
  3. If the bit shifted out of acc[4*DIGITS-1] is 1, set ovf (sticky for this conversion).
  4. Decrement the counter. On the edge that processes the last bit (counter 1 -> 0), go to DONE and drive out_valid=1.
- Latency: out_valid rises exactly BIN_W clock edges after the accepting edge.
- DONE: out_valid=1, in_ready=0. bcd, neg and ovf are held stable until an edge with out_ready=1, then return to IDLE (out_valid=0, in_ready=1 next cycle).
  - If out_ready is already high when out_valid rises, the result is consumed on the next edge (1 cycle in DONE).
  - Minimum accept-to-accept interval: BIN_W+2 cycles.
- Ignored inputs: in_valid is ignored outside IDLE; no input is queued. out_ready is ignored outside DONE.
- Signed corner case: bin = -2^(BIN_W-1) gives magnitude 2^(BIN_W-1), which must convert correctly. Negative zero is impossible, so neg=1 implies a nonzero magnitude.
- Unsigned mode: when SIGNED_EN=0, neg is tied 0 and the MSB is a magnitude bit.
- Output timing: bcd/neg/ovf are registered outputs. Their values outside DONE are don't-care for consumers, but the accumulator is visible mid-conversion. bcd must not glitch in DONE.

Test Plan:
- Exact fit: BIN_W=14, DIGITS=4, unsigned, bin=9999 (14'h270F) -> bcd=16'h9999, ovf=0, neg=0; out_valid rises exactly 14 edges after the accept edge.
- Overflow: bin=12345 -> bcd=16'h2345, ovf=1. bin=10000 -> bcd=16'h0000, ovf=1. bin=0 -> bcd=16'h0000, ovf=0.
- Backpressure: out_ready held 0 for 6 cycles after out_valid, in_valid pulsed during SHIFT and DONE -> bcd stable, in_ready=0 throughout, the extra request is not accepted. After out_ready=1 for 1 edge, in_ready=1 the next cycle.
- Signed, SIGNED_EN=1, BIN_W=14:
  - bin=14'h2000 (-8192) -> neg=1, bcd=16'h8192, ovf=0.
  - bin=14'h3FFF (-1) -> neg=1, bcd=16'h0001.
  - bin=14'h1FFF (8191) -> neg=0, bcd=16'h8191.
- Reset mid-operation: assert rst_n=0 asynchronously 5 edges into SHIFT -> immediately in_ready=1, out_valid=0, bcd=0, ovf=0. After release, bin=255 converts to bcd=16'h0255 with no residue.
- Random sweep (BIN_W=10, DIGITS=3, and BIN_W=20, DIGITS=6) against a golden model, with out_ready randomised -> every result matches value mod 10^DIGITS and ovf matches value>=10^DIGITS.
